// File: rtl/reg_stack_ctrl.sv
// Context-save stack controller: sequences pushes and pops of a nine-register set
// through nine parallel single-port stack RAMs that share one address and write enable.
module reg_stack_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    output logic              restore_en,
    output logic              busy,
    output logic [ADDR_W:0]   depth,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_LD} state_t;

    state_t          state;
    logic [ADDR_W:0] sp;
    logic [ADDR_W:0] sp_dec;
    logic            ovf_set;
    logic            unf_set;

    assign depth = sp;
    assign full  = (sp == CAPACITY);
    assign empty = (sp == '0);

    // Errors are only raised for requests sampled in IDLE; push wins a conflict.
    always_comb begin
        sp_dec  = sp - 1'b1;
        ovf_set = (state == IDLE) && push && full;
        unf_set = (state == IDLE) && !push && pop && empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sp         <= '0;
            addr       <= '0;
            wren       <= 1'b0;
            restore_en <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            ovf <= clr_err ? 1'b0 : (ovf | ovf_set);
            unf <= clr_err ? 1'b0 : (unf | unf_set);
            case (state)
                IDLE: begin
                    if (push) begin
                        if (!full) begin
                            addr  <= sp[ADDR_W-1:0];
                            wren  <= 1'b1;
                            sp    <= sp + 1'b1;
                            busy  <= 1'b1;
                            state <= PUSH_WR;
                        end
                    end else if (pop && !empty) begin
                        addr  <= sp_dec[ADDR_W-1:0];
                        sp    <= sp_dec;
                        wren  <= 1'b0;
                        busy  <= 1'b1;
                        state <= POP_RD;
                    end
                end
                PUSH_WR: begin
                    wren  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                // Address held one cycle so the RAM read data is valid in POP_LD.
                POP_RD: begin
                    restore_en <= 1'b1;
                    state      <= POP_LD;
                end
                POP_LD: begin
                    restore_en <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_stack_ctrl.sv
// Bench for reg_stack_ctrl: an external nine-register RAM harness plus a queue-based
// stack model predicts addresses, depth, flags and the restored register sets.
module tb_reg_stack_ctrl;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic              restore_en;
    logic              busy;
    logic [ADDR_W:0]   depth;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    int checks   = 0;
    int failures = 0;

    // Nine 16-bit registers packed into one word; RAM with one-cycle read latency.
    logic [143:0] regs;
    logic [143:0] ram [0:DEPTH-1];
    logic [143:0] rdata;
    logic [143:0] restored;

    logic [143:0] m_stack[$];
    bit           m_ovf;
    bit           m_unf;

    reg_stack_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
        .addr(addr), .wren(wren), .restore_en(restore_en), .busy(busy),
        .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren) ram[addr] <= regs;
        rdata <= ram[addr];
        if (restore_en) restored <= rdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W:0] m_depth();
        return (ADDR_W+1)'(m_stack.size());
    endfunction

    task automatic model_reset();
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // One request issued from IDLE, followed through to completion.
    task automatic do_op(input bit p, input bit q, input bit c, input string tag);
        logic [159:0] w;
        logic [143:0] d;
        logic [143:0] exp_d;
        logic [ADDR_W:0] ea;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d = w[143:0];
        regs = d; push = p; pop = q; clr_err = c;
        step();
        push = 0; pop = 0; clr_err = 0;
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (p && m_stack.size() < DEPTH) begin
            ea = m_depth();
            m_stack.push_back(d);
            checks++; if (wren !== 1'b1) begin failures++; $display("FAIL %s wren: got %b want 1", tag, wren); end
            checks++; if (addr !== ea[ADDR_W-1:0]) begin failures++; $display("FAIL %s push_addr: got %0d want %0d", tag, addr, ea); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s push_busy: got %b want 1", tag, busy); end
            checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL %s push_restore: got %b want 0", tag, restore_en); end
            step();
            checks++; if (wren !== 1'b0) begin failures++; $display("FAIL %s wren_end: got %b want 0", tag, wren); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s push_busy_end: got %b want 0", tag, busy); end
        end else if (p) begin
            if (!c) m_ovf = 1;
            checks++; if (wren !== 1'b0) begin failures++; $display("FAIL %s ovf_wren: got %b want 0", tag, wren); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s ovf_busy: got %b want 0", tag, busy); end
        end else if (q && m_stack.size() > 0) begin
            exp_d = m_stack.pop_back();
            ea = m_depth();
            checks++; if (addr !== ea[ADDR_W-1:0]) begin failures++; $display("FAIL %s pop_addr: got %0d want %0d", tag, addr, ea); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s pop_busy: got %b want 1", tag, busy); end
            checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL %s pop_rd_restore: got %b want 0", tag, restore_en); end
            checks++; if (wren !== 1'b0) begin failures++; $display("FAIL %s pop_wren: got %b want 0", tag, wren); end
            step();
            checks++; if (restore_en !== 1'b1) begin failures++; $display("FAIL %s pop_ld_restore: got %b want 1", tag, restore_en); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s pop_ld_busy: got %b want 1", tag, busy); end
            checks++; if (wren !== 1'b0) begin failures++; $display("FAIL %s pop_ld_wren: got %b want 0", tag, wren); end
            step();
            checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL %s restore_end: got %b want 0", tag, restore_en); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s pop_busy_end: got %b want 0", tag, busy); end
            checks++; if (restored !== exp_d) begin failures++; $display("FAIL %s restored: got %h want %h", tag, restored, exp_d); end
        end else if (q) begin
            if (!c) m_unf = 1;
            checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL %s unf_restore: got %b want 0", tag, restore_en); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s unf_busy: got %b want 0", tag, busy); end
            step();
            checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL %s unf_restore2: got %b want 0", tag, restore_en); end
        end
        checks++; if (depth !== m_depth()) begin failures++; $display("FAIL %s depth: got %0d want %0d", tag, depth, m_depth()); end
        checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL %s ovf: got %b want %b", tag, ovf, m_ovf); end
        checks++; if (unf !== m_unf) begin failures++; $display("FAIL %s unf: got %b want %b", tag, unf, m_unf); end
        checks++; if (full !== (m_stack.size() == DEPTH)) begin failures++; $display("FAIL %s full: got %b want %b", tag, full, m_stack.size() == DEPTH); end
        checks++; if (empty !== (m_stack.size() == 0)) begin failures++; $display("FAIL %s empty: got %b want %b", tag, empty, m_stack.size() == 0); end
    endtask

    task automatic test_reset();
        rst = 1; push = 0; pop = 0; clr_err = 0; regs = '0;
        step();
        step();
        rst = 0;
        model_reset();
        checks++; if (depth !== '0) begin failures++; $display("FAIL reset_depth: got %0d want 0", depth); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full: got %b%b want 10", empty, full); end
        checks++; if (addr !== '0 || wren !== 1'b0) begin failures++; $display("FAIL reset_addr_wren: got %0d %b want 0 0", addr, wren); end
        checks++; if (restore_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_restore_busy: got %b %b want 0 0", restore_en, busy); end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin failures++; $display("FAIL reset_flags: got %b %b want 0 0", ovf, unf); end
    endtask

    task automatic test_push_pop();
        do_op(1, 0, 0, "single_push");
        do_op(0, 1, 0, "single_pop");
    endtask

    task automatic test_lifo();
        for (int i = 0; i < 3; i++) do_op(1, 0, 0, "lifo_push");
        for (int i = 0; i < 3; i++) do_op(0, 1, 0, "lifo_pop");
    endtask

    task automatic test_empty();
        do_op(0, 1, 0, "empty_pop");
        checks++; if (unf !== 1'b1) begin failures++; $display("FAIL empty_unf_set: got %b want 1", unf); end
        do_op(0, 1, 1, "empty_pop_clr");
        checks++; if (unf !== 1'b0) begin failures++; $display("FAIL empty_clr_wins: got %b want 0", unf); end
    endtask

    task automatic test_conflict_busy();
        logic [143:0] e1;
        logic [143:0] e2;
        do_op(1, 0, 0, "conf_push");
        do_op(1, 0, 0, "conf_push");
        do_op(1, 1, 0, "conf_both");
        checks++; if (depth !== 7'd3) begin failures++; $display("FAIL conflict_depth: got %0d want 3", depth); end
        e1 = m_stack.pop_back();
        e2 = m_stack.pop_back();
        pop = 1;
        step();
        checks++; if (depth !== 7'd2 || busy !== 1'b1) begin failures++; $display("FAIL held_pop_accept: depth %0d busy %b want 2 1", depth, busy); end
        step();
        checks++; if (depth !== 7'd2 || restore_en !== 1'b1) begin failures++; $display("FAIL held_pop_ld: depth %0d restore %b want 2 1", depth, restore_en); end
        step();
        checks++; if (depth !== 7'd2 || busy !== 1'b0) begin failures++; $display("FAIL held_pop_idle: depth %0d busy %b want 2 0", depth, busy); end
        checks++; if (restored !== e1) begin failures++; $display("FAIL held_pop_data1: got %h want %h", restored, e1); end
        step();
        pop = 0;
        checks++; if (depth !== 7'd1 || busy !== 1'b1 || addr !== 6'd1) begin failures++; $display("FAIL held_pop_second: depth %0d busy %b addr %0d want 1 1 1", depth, busy, addr); end
        step();
        step();
        checks++; if (restored !== e2) begin failures++; $display("FAIL held_pop_data2: got %h want %h", restored, e2); end
        do_op(0, 1, 0, "conf_drain");
    endtask

    task automatic test_full();
        while (m_stack.size() < DEPTH) do_op(1, 0, 0, "fill_push");
        checks++; if (full !== 1'b1 || depth !== 7'd64) begin failures++; $display("FAIL full_reached: full %b depth %0d want 1 64", full, depth); end
        do_op(1, 0, 0, "push_when_full");
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf); end
        do_op(1, 1, 0, "both_when_full");
        do_op(0, 0, 1, "clr_ovf");
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", ovf); end
        while (m_stack.size() > 0) do_op(0, 1, 0, "drain_pop");
    endtask

    task automatic test_reset_mid_op();
        do_op(1, 0, 0, "rmp_push");
        do_op(1, 0, 0, "rmp_push");
        pop = 1;
        step();
        pop = 0;
        rst = 1;
        step();
        rst = 0;
        model_reset();
        checks++; if (restore_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_pop_ctrl: restore %b busy %b want 0 0", restore_en, busy); end
        checks++; if (depth !== '0 || addr !== '0) begin failures++; $display("FAIL rst_pop_depth: depth %0d addr %0d want 0 0", depth, addr); end
        step();
        checks++; if (restore_en !== 1'b0) begin failures++; $display("FAIL rst_pop_no_restore: got %b want 0", restore_en); end
        do_op(1, 0, 0, "rmp_idle_push");
        push = 1;
        step();
        push = 0;
        rst = 1;
        step();
        rst = 0;
        model_reset();
        checks++; if (wren !== 1'b0 || depth !== '0) begin failures++; $display("FAIL rst_push_abort: wren %b depth %0d want 0 0", wren, depth); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_lifo();
        test_empty();
        test_conflict_busy();
        test_full();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
